// File: rtl/mem_port_arbiter_if.sv
// Bundles both master ports and the memory-side bus of the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the masters plus memory.
`timescale 1ns/1ps
interface mem_port_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;

    logic [31:0] mem_address;
    logic        mem_write_wire;
    logic        mem_read_wire;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_address, mem_write_wire, mem_read_wire, mem_write_data,
        input  mem_read_data,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_address, mem_write_wire, mem_read_wire, mem_write_data,
        output mem_read_data,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port data-memory arbiter; ack 1/2/3 cycles after grant (error/write/read), one access in flight.
// Losers hold req until ack; MEM_ARB_RR_EN selects round-robin instead of fixed priority + starvation guard.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned ADDR_LIMIT   = 1048576,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            r_state;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_port;
    logic [1:0]        r_ack;
    logic [1:0]        r_err;
    logic [1:0][31:0]  r_rdata;
    logic [31:0]       r_mem_address;
    logic [31:0]       r_mem_write_data;
    logic              r_mem_write;
    logic              r_mem_read;
    logic              r_busy;

    logic              w_any_req;
    logic              w_pick1;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_we;
    logic              w_sel_oor;

`ifdef MEM_ARB_RR_EN
    // Pointer names the port granted last; a tie goes to the other one.
    logic              r_rr_ptr;
    assign w_pick1 = bus.m1_req && (!bus.m0_req || !r_rr_ptr);
`else
    logic [3:0]        r_starve_cnt;
    assign w_pick1 = bus.m1_req && (!bus.m0_req || (r_starve_cnt == 4'(STARVE_LIMIT)));
`endif

    assign w_any_req   = bus.m0_req | bus.m1_req;
    assign w_sel_addr  = w_pick1 ? bus.m1_addr  : bus.m0_addr;
    assign w_sel_wdata = w_pick1 ? bus.m1_wdata : bus.m0_wdata;
    assign w_sel_we    = w_pick1 ? bus.m1_we    : bus.m0_we;
    assign w_sel_oor   = (w_sel_addr > ADDR_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_we             <= 1'b0;
            r_port           <= 1'b0;
            r_ack            <= '0;
            r_err            <= '0;
            r_rdata          <= '0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_busy           <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_rr_ptr         <= 1'b1;
`else
            r_starve_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifndef MEM_ARB_RR_EN
                    // Counts port-0 wins only while port 1 is actually waiting.
                    if (!bus.m1_req || w_pick1) begin
                        r_starve_cnt <= '0;
                    end else begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
`endif
                    if (w_any_req) begin
                        r_port  <= w_pick1;
                        r_addr  <= w_sel_addr;
                        r_we    <= w_sel_we;
                        r_wdata <= w_sel_wdata;
                        r_busy  <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        r_rr_ptr <= w_pick1;
`endif
                        if (w_sel_oor) begin
                            r_state          <= RESP;
                            r_ack[w_pick1]   <= 1'b1;
                            r_err[w_pick1]   <= 1'b1;
                            r_rdata[w_pick1] <= '0;
                        end else begin
                            r_state          <= ISSUE;
                            r_mem_address    <= w_sel_addr;
                            r_mem_write      <= w_sel_we;
                            r_mem_read       <= !w_sel_we;
                            r_mem_write_data <= w_sel_we ? w_sel_wdata : 32'h0;
                        end
                    end
                end

                ISSUE: begin
                    r_mem_write      <= 1'b0;
                    r_mem_read       <= 1'b0;
                    r_mem_write_data <= '0;
                    if (r_we) begin
                        r_state       <= RESP;
                        r_ack[r_port] <= 1'b1;
                    end else begin
                        r_state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    // Memory registered its read at the ISSUE->CAPTURE edge.
                    r_rdata[r_port] <= bus.mem_read_data;
                    r_ack[r_port]   <= 1'b1;
                    r_state         <= RESP;
                end

                RESP: begin
                    r_ack   <= '0;
                    r_err   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m0_ack         = r_ack[0];
    assign bus.m1_ack         = r_ack[1];
    assign bus.m0_err         = r_err[0];
    assign bus.m1_err         = r_err[1];
    assign bus.m0_rdata       = r_rdata[0];
    assign bus.m1_rdata       = r_rdata[1];
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_data = r_mem_write_data;
    assign bus.mem_write_wire = r_mem_write;
    assign bus.mem_read_wire  = r_mem_read;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed latency/arbitration/reset cases plus random two-master traffic
// checked against a word-level memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_LIMIT   = 1048576;
    localparam int unsigned STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .ADDR_LIMIT   (ADDR_LIMIT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory device: write on negedge, registered read on posedge.
    logic [31:0] mem [logic [31:0]];
    always @(negedge clk) begin
        if (bus.mem_write_wire) mem[bus.mem_address] = bus.mem_write_data;
    end
    always @(posedge clk) begin
        if (bus.mem_read_wire)
            bus.mem_read_data <= mem.exists(bus.mem_address) ? mem[bus.mem_address] : 32'h0;
    end

    // Reference contents as seen by the masters: updated when a write is acknowledged.
    logic [31:0] ref_mem [logic [31:0]];

    int   m0_acks = 0, m1_acks = 0, wr_strobes = 0, rd_strobes = 0;
    int   both_strobes = 0, both_acks = 0;
    logic last_port = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) last_port = 1'b1;
        if (bus.m0_ack) begin m0_acks++; last_port = 1'b0; end
        if (bus.m1_ack) begin m1_acks++; last_port = 1'b1; end
        if (bus.m0_ack && bus.m1_ack) both_acks++;
        if (bus.mem_write_wire) wr_strobes++;
        if (bus.mem_read_wire) rd_strobes++;
        if (bus.mem_write_wire && bus.mem_read_wire) both_strobes++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues one access on port p (caller is #1 after a posedge); returns cycles to ack.
    task automatic do_req(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
        logic        got_ack, got_err, exp_err;
        logic [31:0] got_rd, exp_rd;
        exp_err = (addr > ADDR_LIMIT);
        if (p == 0) begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
        lat = 0;
        got_ack = 1'b0;
        while (!got_ack && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            got_ack = (p == 0) ? bus.m0_ack : bus.m1_ack;
        end
        got_err = (p == 0) ? bus.m0_err   : bus.m1_err;
        got_rd  = (p == 0) ? bus.m0_rdata : bus.m1_rdata;
        if (p == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
        chk_eq($sformatf("p%0d_ack_seen", p), 32'(got_ack), 32'd1);
        chk_eq($sformatf("p%0d_err@%08h", p, addr), 32'(got_err), 32'(exp_err));
        if (!we || exp_err) begin
            exp_rd = exp_err ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : 32'h0);
            chk_eq($sformatf("p%0d_rdata@%08h", p, addr), got_rd, exp_rd);
        end else begin
            ref_mem[addr] = wdata;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 32'(ADDR_LIMIT);
        if (sel == 1) return 32'(ADDR_LIMIT) + 32'd1 + 32'($urandom_range(0, 1000));
        return 32'($urandom_range(0, 15));
    endfunction

    int   lat_a, lat_b, base_wr, base_rd, base_m0, base_acks;
    int   exp_before, exp_win_lat0, exp_win_lat1;
    logic tie_start_port;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        rst_n = 1'b0;
        idle(2);
        chk_eq("rst_m0_ack", 32'(bus.m0_ack), 0);
        chk_eq("rst_m1_ack", 32'(bus.m1_ack), 0);
        chk_eq("rst_errs", 32'({bus.m0_err, bus.m1_err}), 0);
        chk_eq("rst_strobes", 32'({bus.mem_write_wire, bus.mem_read_wire}), 0);
        chk_eq("rst_busy", 32'(bus.busy), 0);
        chk_eq("rst_m0_rdata", bus.m0_rdata, 0);
        chk_eq("rst_m1_rdata", bus.m1_rdata, 0);
        chk_eq("rst_mem_address", bus.mem_address, 0);
        chk_eq("rst_mem_wdata", bus.mem_write_data, 0);
        @(negedge clk) rst_n = 1'b1;
        idle(1);

        // Write then read back on port 0.
        base_wr = wr_strobes; base_rd = rd_strobes;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, lat_a);
        chk_eq("wr_latency", 32'(lat_a), 2);
        chk_eq("wr_strobe_cycles", 32'(wr_strobes - base_wr), 1);
        chk_eq("wr_no_read_strobe", 32'(rd_strobes - base_rd), 0);
        chk_eq("mem_0x10", mem[32'h10], 32'hDEADBEEF);
        idle(2);
        base_wr = wr_strobes; base_rd = rd_strobes;
        do_req(0, 1'b0, 32'h10, 32'h0, lat_a);
        chk_eq("rd_latency", 32'(lat_a), 3);
        chk_eq("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        chk_eq("rd_strobe_cycles", 32'(rd_strobes - base_rd), 1);
        chk_eq("rd_no_write_strobe", 32'(wr_strobes - base_wr), 0);
        idle(2);
        do_req(0, 1'b1, 32'h30, 32'h0BADF00D, lat_a);
        chk_eq("rdata_holds_over_write", bus.m0_rdata, 32'hDEADBEEF);
        idle(2);

        // Highest legal address, then out-of-range on port 1.
        do_req(0, 1'b1, 32'(ADDR_LIMIT), 32'hA5A5A5A5, lat_a);
        chk_eq("limit_wr_latency", 32'(lat_a), 2);
        idle(2);
        do_req(1, 1'b0, 32'(ADDR_LIMIT), 32'h0, lat_a);
        chk_eq("limit_rd_latency", 32'(lat_a), 3);
        idle(2);
        base_wr = wr_strobes; base_rd = rd_strobes;
        do_req(1, 1'b0, 32'h00100001, 32'h0, lat_a);
        chk_eq("oor_latency", 32'(lat_a), 1);
        chk_eq("oor_m1_rdata", bus.m1_rdata, 0);
        chk_eq("oor_no_strobe", 32'((wr_strobes - base_wr) + (rd_strobes - base_rd)), 0);
        idle(2);

        // Simultaneous reads from both ports.
        do_req(0, 1'b1, 32'h4, 32'h44444444, lat_a);
        idle(2);
        do_req(1, 1'b1, 32'h8, 32'h88888888, lat_a);
        idle(2);
`ifdef MEM_ARB_RR_EN
        exp_win_lat0 = (last_port == 1'b1) ? 3 : 7;
`else
        exp_win_lat0 = 3;
`endif
        exp_win_lat1 = (exp_win_lat0 == 3) ? 7 : 3;
        fork
            do_req(0, 1'b0, 32'h4, 32'h0, lat_a);
            do_req(1, 1'b0, 32'h8, 32'h0, lat_b);
        join
        chk_eq("tie_p0_latency", 32'(lat_a), 32'(exp_win_lat0));
        chk_eq("tie_p1_latency", 32'(lat_b), 32'(exp_win_lat1));
        idle(2);

        // Port 0 streams reads while port 1 waits, twice.
        for (int r = 0; r < 2; r++) begin
            tie_start_port = last_port;
`ifdef MEM_ARB_RR_EN
            exp_before = (tie_start_port == 1'b1) ? 1 : 0;
`else
            exp_before = STARVE_LIMIT;
`endif
            base_m0 = m0_acks;
            fork
                begin
                    for (int k = 0; k < 6; k++) do_req(0, 1'b0, 32'(k), 32'h0, lat_a);
                end
                begin
                    do_req(1, 1'b0, 32'h8, 32'h0, lat_b);
                    chk_eq($sformatf("starve_round%0d_p0_grants", r), 32'(m0_acks - base_m0),
                           32'(exp_before));
                end
            join
            idle(2);
        end

        // Reset during ISSUE of a write: nothing reaches memory, no ack.
        do_req(0, 1'b1, 32'h20, 32'h11111111, lat_a);
        idle(2);
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h20; bus.m0_wdata = 32'h22222222;
        @(posedge clk); #1;
        chk_eq("issue_wr_strobe", 32'(bus.mem_write_wire), 1);
        rst_n = 1'b0;
        #1;
        chk_eq("rst_mid_strobes", 32'({bus.mem_write_wire, bus.mem_read_wire}), 0);
        chk_eq("rst_mid_busy", 32'(bus.busy), 0);
        chk_eq("rst_mid_ack", 32'(bus.m0_ack), 0);
        bus.m0_req = 1'b0;
        base_acks = m0_acks + m1_acks;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(4);
        chk_eq("rst_mid_no_ack", 32'(m0_acks + m1_acks - base_acks), 0);
        chk_eq("rst_mid_idle", 32'(bus.busy), 0);
        chk_eq("rst_mid_mem_0x20", mem[32'h20], 32'h11111111);
        do_req(0, 1'b0, 32'h20, 32'h0, lat_a);
        chk_eq("post_rst_rd_latency", 32'(lat_a), 3);
        idle(2);

        // Random traffic from both masters.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    idle($urandom_range(0, 3));
                    do_req(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, lat_a);
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    idle($urandom_range(0, 3));
                    do_req(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, lat_b);
                end
            end
        join
        idle(3);

        chk_eq("never_both_strobes", 32'(both_strobes), 0);
        chk_eq("never_both_acks", 32'(both_acks), 0);
        chk_eq("final_busy", 32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
